// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte path: data width, default TX FIFO
// depth and the output-stage state encoding reused by the RX-side FIFO.
package uart_pkg;

    localparam int DATA_W   = 8;
    localparam int TX_DEPTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fifo_out_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART FIFOs: one synchronous write port and one
// asynchronous read port. Contents are never reset; the pointers that
// index them are what define which entries hold valid data.
module uart_fifo_mem #(
    parameter  int DATA_W = uart_pkg::DATA_W,
    parameter  int DEPTH  = uart_pkg::TX_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming byte at the write address when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter. Bytes written by the host
// go through a circular array and are handed to the transmitter through a
// registered valid/ready output stage, so the host need not pace writes
// to the baud rate. Occupancy counts the array plus the output register.
module uart_tx_fifo #(
    parameter  int DATA_W = uart_pkg::DATA_W,
    parameter  int DEPTH  = uart_pkg::TX_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    import uart_pkg::*;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     arr_count;
    logic [DATA_W-1:0] rd_data;
    logic              arr_empty;
    logic              do_write;
    logic              do_pop;
    fifo_out_state_t   state;

    assign arr_empty = (arr_count == '0);
    assign full      = (arr_count == CW'(DEPTH));
    assign empty     = arr_empty && !tx_valid;
    assign count     = arr_count + {{(CW-1){1'b0}}, tx_valid};

    // A full array drops the write even if a pop frees a slot this cycle.
    assign do_write  = wr_en && !full;
    // The output register reloads when it is empty or being taken.
    assign do_pop    = !arr_empty && ((state == ST_IDLE) || tx_ready);

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_write),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Advance the circular pointers; DEPTH is a power of two so they wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Track array occupancy; a simultaneous write and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_count <= '0;
        end else begin
            case ({do_write, do_pop})
                2'b10:   arr_count <= arr_count + CW'(1);
                2'b01:   arr_count <= arr_count - CW'(1);
                default: arr_count <= arr_count;
            endcase
        end
    end

    // Output stage: load the oldest byte, hold it until taken, reload back-to-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!arr_empty) begin
                        tx_data  <= rd_data;
                        tx_valid <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tx_ready) begin
                        if (!arr_empty) begin
                            tx_data <= rd_data;
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped write sets it and wins over a clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, single-byte latency, fill to
// DEPTH+1 with overflow and its clear priority, steady streaming,
// pointer wrap at partial fill and asynchronous reset mid-stream.
module tb_uart_tx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH + 2);

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              ovf_clr;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    int vectors;
    int miscompares;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain_bytes(input string tag, input logic [7:0] first, input int n);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 16'(tx_valid), 16'd1);
            check({tag, "_data"}, 16'(tx_data), 16'(first + 8'(i)));
            tick();
        end
        check({tag, "_done_valid"}, 16'(tx_valid), 16'd0);
        check({tag, "_done_empty"}, 16'(empty), 16'd1);
        tx_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        ovf_clr  = 1'b0;
        tx_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        check("rst_valid", 16'(tx_valid), 16'd0);
        check("rst_data", 16'(tx_data), 16'h00);
        check("rst_count", 16'(count), 16'd0);
        check("rst_full", 16'(full), 16'd0);
        check("rst_empty", 16'(empty), 16'd1);
        check("rst_ovf", 16'(overflow), 16'd0);

        // Single byte: in the array after edge N, in the output after N+1
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("t1_n_valid", 16'(tx_valid), 16'd0);
        check("t1_n_count", 16'(count), 16'd1);
        check("t1_n_empty", 16'(empty), 16'd0);
        tick();
        check("t1_n1_valid", 16'(tx_valid), 16'd1);
        check("t1_n1_data", 16'(tx_data), 16'hA5);
        check("t1_n1_count", 16'(count), 16'd1);
        check("t1_n1_empty", 16'(empty), 16'd0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("t1_take_valid", 16'(tx_valid), 16'd0);
        check("t1_take_count", 16'(count), 16'd0);
        check("t1_take_empty", 16'(empty), 16'd1);

        // Fill to DEPTH+1: one byte in the output register, DEPTH in the array
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
            check("t2_fill_count", 16'(count), 16'(i + 1));
            check("t2_fill_full", 16'(full), (i == 16) ? 16'd1 : 16'd0);
        end
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        check("t2_drop_ovf", 16'(overflow), 16'd1);
        check("t2_drop_count", 16'(count), 16'd17);
        check("t2_drop_full", 16'(full), 16'd1);

        // Overflow clear alone, then set and clear together (set wins)
        ovf_clr = 1'b1;
        tick();
        check("t5_clr_ovf", 16'(overflow), 16'd0);
        wr_en   = 1'b1;
        wr_data = 8'hFE;
        tick();
        wr_en = 1'b0;
        check("t5_both_ovf", 16'(overflow), 16'd1);
        check("t5_both_count", 16'(count), 16'd17);
        tick();
        ovf_clr = 1'b0;
        check("t5_clr2_ovf", 16'(overflow), 16'd0);

        // Drain: exactly 0x00..0x10, no 0xFF or 0xFE
        drain_bytes("t2_drain", 8'h00, 17);

        // Streaming: after the fill one byte sits in the array and one in the output
        tx_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h20 + 8'(i);
            tick();
            if (i == 0) begin
                check("t3_fill_count", 16'(count), 16'd1);
                check("t3_fill_valid", 16'(tx_valid), 16'd0);
            end else begin
                check("t3_count", 16'(count), 16'd2);
                check("t3_valid", 16'(tx_valid), 16'd1);
                check("t3_data", 16'(tx_data), 16'(8'h20 + 8'(i - 1)));
            end
        end
        wr_en = 1'b0;
        tick();
        check("t3_tail_data", 16'(tx_data), 16'h83);
        check("t3_tail_count", 16'(count), 16'd1);
        tick();
        tx_ready = 1'b0;
        check("t3_end_valid", 16'(tx_valid), 16'd0);
        check("t3_end_count", 16'(count), 16'd0);

        // Partial fills that cross the array wrap point
        write_bytes(8'h40, 10);
        drain_bytes("t4_a", 8'h40, 10);
        write_bytes(8'h60, 12);
        check("t4_b_count", 16'(count), 16'd12);
        drain_bytes("t4_b", 8'h60, 12);

        // Asynchronous reset with one byte offered and five stored
        write_bytes(8'h90, 6);
        check("t6_pre_count", 16'(count), 16'd6);
        check("t6_pre_valid", 16'(tx_valid), 16'd1);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", 16'(tx_valid), 16'd0);
        check("t6_rst_count", 16'(count), 16'd0);
        check("t6_rst_full", 16'(full), 16'd0);
        check("t6_rst_ovf", 16'(overflow), 16'd0);
        check("t6_rst_empty", 16'(empty), 16'd1);
        tick();
        rst = 1'b1;
        write_bytes(8'h77, 1);
        check("t6_new_n_valid", 16'(tx_valid), 16'd0);
        tick();
        check("t6_new_valid", 16'(tx_valid), 16'd1);
        check("t6_new_data", 16'(tx_data), 16'h77);
        check("t6_new_count", 16'(count), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
